// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the immediate generator.
// No logic, no latency.
// No flow control of its own.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6,
        FMT_Z    = 3'd7
    } imm_fmt_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // True for the funct3 values that select a shift-amount immediate.
    function automatic logic is_shift_f3(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational instr -> {imm, fmt, illegal} decode; IMM_ZICSR_EN adds CSR zimm.
// Latency: zero (pure combinational).
// No flow control; the caller registers the result.
module imm_decode_comb
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // 32-bit sign-extended forms; widened to XLEN below by a signed cast.
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Opcode-driven format selection; opcodes not listed are flagged illegal.
    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                if (is_shift_f3(funct3)) begin
                    fmt = FMT_SH;
                    imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
                end else begin
                    fmt = FMT_I;
                    imm = XLEN'($signed(imm_i));
                end
            end
            OPC_OP_IMM_32: begin
                // Word-op immediates only exist on a 64-bit core.
                if (XLEN == 64) begin
                    if (is_shift_f3(funct3)) begin
                        fmt = FMT_SH;
                        imm = XLEN'(instr[24:20]);
                    end else begin
                        fmt = FMT_I;
                        imm = XLEN'($signed(imm_i));
                    end
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_LOAD, OPC_JALR: begin
                fmt = FMT_I;
                imm = XLEN'($signed(imm_i));
            end
            OPC_STORE: begin
                fmt = FMT_S;
                imm = XLEN'($signed(imm_s));
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                imm = XLEN'($signed(imm_b));
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                imm = XLEN'($signed(imm_u));
            end
            OPC_JAL: begin
                fmt = FMT_J;
                imm = XLEN'($signed(imm_j));
            end
            OPC_OP, OPC_OP_32, OPC_MISC_MEM: begin
                fmt = FMT_NONE;
            end
            OPC_SYSTEM: begin
`ifdef IMM_ZICSR_EN
                if (funct3[2] && (funct3[1:0] != 2'b00)) begin
                    fmt = FMT_Z;
                    imm = XLEN'(instr[19:15]);
                end else begin
                    fmt = FMT_I;
                    imm = XLEN'($signed(imm_i));
                end
`else
                fmt = FMT_NONE;
`endif
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with tag sideband; IMM_ZICSR_EN enables CSR zimm decode.
// Latency: 1 cycle from input handshake to out_valid when the output register is free.
// Backpressure: 2-entry (output + skid) buffer; in_ready is registered and drops once skid fills.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output imm_fmt_e         out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_cnt
);

    // Widths depend on module parameters, so the entry layout is declared here.
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t dec_entry;
    entry_t out_q;
    entry_t skid_q;
    logic   skid_valid;
    logic   in_fire;
    logic   out_fire;
    logic   out_free;

    imm_decode_comb #(.XLEN(XLEN)) u_decode (
        .instr   (in_instr),
        .imm     (dec_entry.imm),
        .fmt     (dec_entry.fmt),
        .illegal (dec_entry.illegal)
    );
    assign dec_entry.tag = in_tag;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign out_free = ~out_valid | out_ready;

    // Output/skid registers: skid drains first to keep FIFO order; flush empties both.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
            out_q      <= '{imm: '0, fmt: FMT_NONE, illegal: 1'b0, tag: '0};
            skid_q     <= '{imm: '0, fmt: FMT_NONE, illegal: 1'b0, tag: '0};
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (out_free) begin
            if (skid_valid) begin
                // in_ready was low, so no new entry can arrive this cycle.
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
                in_ready   <= 1'b1;
            end else if (in_fire) begin
                out_q     <= dec_entry;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_fire) begin
            skid_q     <= dec_entry;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
        end
    end

    // Saturating count of illegal entries actually handed to the consumer.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_cnt <= '0;
        end else if (out_fire && out_q.illegal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.illegal;
    assign out_tag     = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: a 32-bit and a 64-bit instance share one stimulus stream.
// Expected entries are queued on input handshake and popped by a negedge monitor.
// Both instances use a 2-bit illegal counter so saturation is reachable.
module tb_imm_gen_pipe;
    import imm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [31:0] in_tag;

    logic        rdy32, vld32, ill32;
    logic [31:0] imm32, tag32;
    imm_fmt_e    fmt32;
    logic [1:0]  cnt32;

    logic        rdy64, vld64, ill64;
    logic [63:0] imm64;
    logic [31:0] tag64;
    imm_fmt_e    fmt64;
    logic [1:0]  cnt64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(2)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
        .out_illegal(ill32), .out_tag(tag32), .illegal_cnt(cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .CNT_W(2)) dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
        .out_illegal(ill64), .out_tag(tag64), .illegal_cnt(cnt64)
    );

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] tag;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] imm32;
        logic [63:0] imm64;
        logic [2:0]  fmt;
        logic        ill;
    } dir_t;

    exp_t q32[$];
    exp_t q64[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    int   ecnt32 = 0;
    int   ecnt64 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the immediate-format rules, using plain arithmetic.
    function automatic exp_t mdl(input logic [31:0] ins, input bit rv64, input logic [31:0] tg);
        exp_t   e;
        longint v;
        longint ii;
        logic [2:0] f3;
        f3    = ins[14:12];
        ii    = longint'(ins[31:20]) - (ins[31] ? 64'sd4096 : 64'sd0);
        v     = 0;
        e.fmt = FMT_NONE;
        e.ill = 1'b0;
        e.tag = tg;
        case (ins[6:0])
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.fmt = FMT_SH;
                    v = rv64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
                end else begin
                    e.fmt = FMT_I; v = ii;
                end
            end
            7'h1B: begin
                if (!rv64) e.ill = 1'b1;
                else if (f3 == 3'd1 || f3 == 3'd5) begin e.fmt = FMT_SH; v = longint'(ins[24:20]); end
                else begin e.fmt = FMT_I; v = ii; end
            end
            7'h03, 7'h67: begin e.fmt = FMT_I; v = ii; end
            7'h23: begin
                e.fmt = FMT_S;
                v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]) - (ins[31] ? 64'sd4096 : 64'sd0);
            end
            7'h63: begin
                e.fmt = FMT_B;
                v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2
                    - (ins[31] ? 64'sd4096 : 64'sd0);
            end
            7'h37, 7'h17: begin
                e.fmt = FMT_U;
                v = longint'(ins[31:12]) * 4096 - (ins[31] ? 64'sh1_0000_0000 : 64'sd0);
            end
            7'h6F: begin
                e.fmt = FMT_J;
                v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2
                    - (ins[31] ? 64'sh10_0000 : 64'sd0);
            end
            7'h33, 7'h3B, 7'h0F: e.fmt = FMT_NONE;
            7'h73: begin
`ifdef IMM_ZICSR_EN
                if (f3 >= 3'd5) begin e.fmt = FMT_Z; v = longint'(ins[19:15]); end
                else begin e.fmt = FMT_I; v = ii; end
`else
                e.fmt = FMT_NONE;
`endif
            end
            default: e.ill = 1'b1;
        endcase
        e.imm = v;
        return e;
    endfunction

    // Monitor: compare what each DUT presents against the head of its queue.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            check("in_ready32", rdy32, q32.size() < 2);
            check("in_ready64", rdy64, q64.size() < 2);
            check("out_valid32", vld32, q32.size() > 0);
            check("out_valid64", vld64, q64.size() > 0);
            check("illegal_cnt32", cnt32, ecnt32);
            check("illegal_cnt64", cnt64, ecnt64);
            if (vld32 && q32.size() > 0) begin
                check("imm32", imm32, q32[0].imm[31:0]);
                check("fmt32", fmt32, q32[0].fmt);
                check("illegal32", ill32, q32[0].ill);
                check("tag32", tag32, q32[0].tag);
                if (out_ready) begin
                    if (q32[0].ill && ecnt32 < 3) ecnt32++;
                    void'(q32.pop_front());
                end
            end
            if (vld64 && q64.size() > 0) begin
                check("imm64", imm64, q64[0].imm);
                check("fmt64", fmt64, q64[0].fmt);
                check("illegal64", ill64, q64[0].ill);
                check("tag64", tag64, q64[0].tag);
                if (out_ready) begin
                    if (q64[0].ill && ecnt64 < 3) ecnt64++;
                    void'(q64.pop_front());
                end
            end
        end
    end

    // One cycle of stimulus; starts just after a posedge and returns just after the next.
    task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] tg, input bit ordy,
                         input bit fl, input exp_t e32, input exp_t e64, output bit acc);
        in_valid  = v;
        in_instr  = ins;
        in_tag    = tg;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        acc = v && rdy32 && !fl;
        @(posedge clk);
        if (fl) begin
            q32.delete();
            q64.delete();
        end else if (acc) begin
            q32.push_back(e32);
            q64.push_back(e64);
        end
        #1;
    endtask

    task automatic send(input bit v, input logic [31:0] ins, input bit ordy, input bit fl, output bit acc);
        logic [31:0] tg;
        tg = $urandom;
        drive(v, ins, tg, ordy, fl, mdl(ins, 1'b0, tg), mdl(ins, 1'b1, tg), acc);
    endtask

    task automatic send_until(input logic [31:0] ins, input bit ordy);
        bit acc;
        int tries;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 20) begin
            send(1'b1, ins, ordy, 1'b0, acc);
            tries++;
        end
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        mon_en    = 1'b0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        q32.delete();
        q64.delete();
        ecnt32 = 0;
        ecnt64 = 0;
        @(negedge clk);
        check("rst_out_valid", {vld32, vld64}, 2'b00);
        check("rst_in_ready", {rdy32, rdy64}, 2'b11);
        check("rst_out_imm", imm32 | imm64, 64'd0);
        check("rst_out_fmt", {fmt32, fmt64}, {FMT_NONE, FMT_NONE});
        check("rst_out_illegal", {ill32, ill64}, 2'b00);
        check("rst_out_tag", tag32 | tag64, 64'd0);
        check("rst_illegal_cnt", {cnt32, cnt64}, 4'd0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    dir_t dirs[12];

    initial begin
        bit   acc;
        exp_t e32;
        exp_t e64;

        dirs[0]  = '{32'hFFF00093, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I,  1'b0};
        dirs[1]  = '{32'hFFC12083, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, FMT_I,  1'b0};
        dirs[2]  = '{32'hFE000CE3, 64'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, FMT_B,  1'b0};
        dirs[3]  = '{32'h123450B7, 64'h1234_5000, 64'h0000_0000_1234_5000, FMT_U,  1'b0};
        dirs[4]  = '{32'h4030D093, 64'h3,         64'h3,                   FMT_SH, 1'b0};
        dirs[5]  = '{32'h03F09093, 64'h1F,        64'h3F,                  FMT_SH, 1'b0};
        dirs[6]  = '{32'hFE112E23, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, FMT_S,  1'b0};
        dirs[7]  = '{32'h0010006F, 64'h800,       64'h800,                 FMT_J,  1'b0};
        dirs[8]  = '{32'h002081B3, 64'h0,         64'h0,                   FMT_NONE, 1'b0};
        dirs[9]  = '{32'h0000007F, 64'h0,         64'h0,                   FMT_NONE, 1'b1};
        dirs[10] = '{32'h00000012, 64'h0,         64'h0,                   FMT_NONE, 1'b1};
`ifdef IMM_ZICSR_EN
        dirs[11] = '{32'h3407D073, 64'hF,         64'hF,                   FMT_Z,  1'b0};
`else
        dirs[11] = '{32'h3407D073, 64'h0,         64'h0,                   FMT_NONE, 1'b0};
`endif

        do_reset();

        // Known encodings back-to-back with the consumer always ready.
        for (int i = 0; i < 12; i++) begin
            e32 = '{dirs[i].imm32, dirs[i].fmt, dirs[i].ill, 32'(i + 100)};
            e64 = '{dirs[i].imm64, dirs[i].fmt, dirs[i].ill, 32'(i + 100)};
            drive(1'b1, dirs[i].ins, 32'(i + 100), 1'b1, 1'b0, e32, e64, acc);
            if (!acc) check("directed_accept", 64'd0, 64'd1);
        end
        send(1'b0, 32'h0, 1'b1, 1'b0, acc);
        send(1'b0, 32'h0, 1'b1, 1'b0, acc);

        // Stall: two entries held, third waits until the skid drains.
        send(1'b1, 32'hFFF00093, 1'b0, 1'b0, acc);
        send(1'b1, 32'h0010006F, 1'b0, 1'b0, acc);
        send(1'b1, 32'h123450B7, 1'b0, 1'b0, acc);
        if (acc) check("stall_third_rejected", 64'd1, 64'd0);
        send(1'b1, 32'h123450B7, 1'b0, 1'b0, acc);
        send_until(32'h123450B7, 1'b1);
        repeat (3) send(1'b0, 32'h0, 1'b1, 1'b0, acc);

        // Flush with both slots full and a new instruction presented.
        send(1'b1, 32'hFE112E23, 1'b0, 1'b0, acc);
        send(1'b1, 32'hFE000CE3, 1'b0, 1'b0, acc);
        send(1'b1, 32'h4030D093, 1'b0, 1'b1, acc);
        repeat (3) send(1'b0, 32'h0, 1'b1, 1'b0, acc);

        // Illegal counter saturation from a clean reset.
        do_reset();
        for (int i = 0; i < 6; i++) send_until(32'h0000007F, 1'b1);
        repeat (2) send(1'b0, 32'h0, 1'b1, 1'b0, acc);

        // Randomized traffic with back-pressure and occasional flush.
        begin
            logic [6:0] ops[14];
            ops = '{7'h13, 7'h1B, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                    7'h17, 7'h6F, 7'h33, 7'h3B, 7'h0F, 7'h73, 7'h00};
            for (int c = 0; c < 800; c++) begin
                logic [31:0] ins;
                logic [6:0]  op;
                bit          v, ordy, fl;
                op = ops[$urandom_range(0, 13)];
                if (op == 7'h00) op = 7'($urandom);
                ins  = {$urandom} ;
                ins[6:0] = op;
                v    = ($urandom_range(0, 3) != 0);
                ordy = ($urandom_range(0, 2) != 0);
                fl   = ($urandom_range(0, 31) == 0);
                if (fl) ordy = 1'b0;
                send(v, ins, ordy, fl, acc);
            end
        end
        repeat (4) send(1'b0, 32'h0, 1'b1, 1'b0, acc);
        check("drained32", q32.size(), 0);
        check("drained64", q64.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
